block_8x8_serializer: RTL and testbench

Output-side counterpart of the 8x8 block buffer. Accepts a processed 8x8 pixel block as eight parallel row transfers, eight 24-bit pixels per row. Stores the block and re-emits it as a raster-order AXI4-Stream master, one pixel per beat, with `last` on the 64th beat. Sits between the 8x8 processing datapath and the DMA/stream sink.

---
 rtl/block_8x8_serializer.sv | 170 +++++++++++++++++
 tb/tb_block_8x8_serializer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_8x8_serializer.sv
`default_nettype none
// ============================================================================
// Module      : block_8x8_serializer
// Description : Stores an 8x8 block of pixels that arrives as eight parallel
//               row transfers, then re-emits it as a raster-order AXI4-Stream
//               master, one pixel per beat, with last on beat 63.
// Option      : SER_PINGPONG_EN - when defined, two storage banks alternate so
//               the next block can be filled while the current one drains.
//               When undefined, a single bank is used: fill, then drain.
// Ports       : i_clk, i_rst (async, active-low)
//               input_data1..8 - row pixels, column 0..7
//               input_valid / input_ready - row handshake
//               m_axis_data / m_axis_valid / m_axis_ready / m_axis_last
//               o_intr - one-cycle pulse after the final beat of a block
// Revision    : 1.0 - initial release
// ============================================================================
module block_8x8_serializer #(
    parameter int PIX_W  = 24,
    parameter int AXIS_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [PIX_W-1:0]  input_data1,
    input  logic [PIX_W-1:0]  input_data2,
    input  logic [PIX_W-1:0]  input_data3,
    input  logic [PIX_W-1:0]  input_data4,
    input  logic [PIX_W-1:0]  input_data5,
    input  logic [PIX_W-1:0]  input_data6,
    input  logic [PIX_W-1:0]  input_data7,
    input  logic [PIX_W-1:0]  input_data8,
    input  logic              input_valid,
    output logic              input_ready,
    output logic [AXIS_W-1:0] m_axis_data,
    output logic              m_axis_valid,
    input  logic              m_axis_ready,
    output logic              m_axis_last,
    output logic              o_intr
);

`ifdef SER_PINGPONG_EN
    localparam int ADDR_W = 7;
`else
    localparam int ADDR_W = 6;
`endif
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [PIX_W-1:0]  r_mem [DEPTH];
    logic [PIX_W-1:0]  w_row [8];
    logic [2:0]        r_row;
    logic [5:0]        r_beat;
    logic [PIX_W-1:0]  r_data;
    logic              r_intr;

    logic              w_accept;
    logic              w_row_last;
    logic              w_hs;
    logic              w_done;
    logic              w_start;
    logic              w_load;
    logic [ADDR_W-1:0] w_wr_base;
    logic [ADDR_W-1:0] w_rd_addr;

    assign w_row[0] = input_data1;
    assign w_row[1] = input_data2;
    assign w_row[2] = input_data3;
    assign w_row[3] = input_data4;
    assign w_row[4] = input_data5;
    assign w_row[5] = input_data6;
    assign w_row[6] = input_data7;
    assign w_row[7] = input_data8;

    assign w_accept     = input_valid && input_ready;
    assign w_row_last   = w_accept && (r_row == 3'd7);
    assign m_axis_valid = (r_state == ST_DRAIN);
    assign w_hs         = m_axis_valid && m_axis_ready;
    assign w_done       = w_hs && (r_beat == 6'd63);
    // Output register reloads when a drain begins or a non-final beat retires.
    assign w_load       = w_start || (w_hs && !w_done);

`ifdef SER_PINGPONG_EN
    logic       r_fill_bank;
    logic       r_drain_bank;
    logic [1:0] r_full;
    logic       w_cand;
    logic       w_can_start;
    logic       w_cand_ready;

    assign input_ready  = !r_full[r_fill_bank];
    // Banks drain in the order they filled; while draining, the next
    // candidate is the other bank.
    assign w_cand       = (r_state == ST_DRAIN) ? ~r_drain_bank : r_drain_bank;
    assign w_can_start  = (r_state == ST_FILL) || w_done;
    // A bank completing this very cycle counts as ready to drain.
    assign w_cand_ready = r_full[w_cand] || (w_row_last && (r_fill_bank == w_cand));
    assign w_start      = w_can_start && w_cand_ready;
    assign w_wr_base    = {r_fill_bank, r_row, 3'b000};
    assign w_rd_addr    = w_start ? {w_cand, 6'd0} : {r_drain_bank, r_beat + 6'd1};

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_fill_bank  <= 1'b0;
            r_drain_bank <= 1'b0;
            r_full       <= 2'b00;
        end else begin
            if (w_row_last) begin
                r_full[r_fill_bank] <= 1'b1;
                r_fill_bank         <= ~r_fill_bank;
            end
            if (w_done) begin
                r_full[r_drain_bank] <= 1'b0;
                r_drain_bank         <= ~r_drain_bank;
            end
        end
    end
`else
    assign input_ready = (r_state == ST_FILL);
    // Row 7 can only be accepted in FILL, so it alone starts the drain.
    assign w_start     = w_row_last;
    assign w_wr_base   = {r_row, 3'b000};
    assign w_rd_addr   = w_start ? 6'd0 : (r_beat + 6'd1);
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FILL:  if (w_start) w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_done && !w_start) w_state_next = ST_FILL;
            default:  w_state_next = ST_FILL;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_FILL;
            r_row   <= 3'd0;
            r_beat  <= 6'd0;
            r_data  <= '0;
            r_intr  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_intr  <= w_done;
            if (w_accept) r_row <= r_row + 3'd1;
            if (w_hs)     r_beat <= r_beat + 6'd1;
            if (w_load)   r_data <= r_mem[w_rd_addr];
        end
    end

    // Storage is not reset; a discarded partial block is simply overwritten.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            for (int c = 0; c < 8; c++) begin
                r_mem[w_wr_base + ADDR_W'(c)] <= w_row[c];
            end
        end
    end

    assign m_axis_data = AXIS_W'(r_data);
    assign m_axis_last = m_axis_valid && (r_beat == 6'd63);
    assign o_intr      = r_intr;

endmodule
`default_nettype wire

// File: tb/tb_block_8x8_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_8x8_serializer
// Description : Self-checking bench for block_8x8_serializer. Rows are driven
//               from a block array; each accepted row pushes its eight
//               expected beats into a scoreboard queue, and a monitor pops and
//               compares on every presented beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_block_8x8_serializer;

    localparam int PIX_W  = 24;
    localparam int AXIS_W = 32;

    typedef struct packed {
        logic [AXIS_W-1:0] data;
        logic              last;
    } beat_t;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b0;
    logic [PIX_W-1:0]  input_data [8];
    logic              input_valid = 1'b0;
    logic              input_ready;
    logic [AXIS_W-1:0] m_axis_data;
    logic              m_axis_valid;
    logic              m_axis_ready = 1'b0;
    logic              m_axis_last;
    logic              o_intr;

    int     checks = 0;
    int     errors = 0;
    beat_t  exp_q[$];
    logic [PIX_W-1:0] blk [64];
    bit     bp_mode = 1'b0;
    int     hs_count = 0;
    int     intr_count = 0;
    longint cyc = 0;
    longint pp_first = -1;
    longint pp_last = 0;

    always #5 i_clk = ~i_clk;

    block_8x8_serializer #(.PIX_W(PIX_W), .AXIS_W(AXIS_W)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .input_data1  (input_data[0]),
        .input_data2  (input_data[1]),
        .input_data3  (input_data[2]),
        .input_data4  (input_data[3]),
        .input_data5  (input_data[4]),
        .input_data6  (input_data[5]),
        .input_data7  (input_data[6]),
        .input_data8  (input_data[7]),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .m_axis_data  (m_axis_data),
        .m_axis_valid (m_axis_valid),
        .m_axis_ready (m_axis_ready),
        .m_axis_last  (m_axis_last),
        .o_intr       (o_intr)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Sink readiness: always 1, or a coin flip each cycle under backpressure.
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            m_axis_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor / scoreboard.
    initial begin
        bit exp_intr   = 1'b0;
        bit prev_stall = 1'b0;
        forever begin
            @(negedge i_clk);
            cyc++;
            if (!i_rst) begin
                exp_intr   = 1'b0;
                prev_stall = 1'b0;
                continue;
            end
            chk("o_intr", o_intr, exp_intr);
            if (o_intr) intr_count++;
            exp_intr = 1'b0;
`ifndef SER_PINGPONG_EN
            chk("input_ready_vs_drain", input_ready, !m_axis_valid);
`endif
            if (prev_stall && !m_axis_valid) begin
                checks++;
                errors++;
                $display("FAIL valid_drop: valid fell without handshake (t=%0t)", $time);
            end
            if (m_axis_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got data %0h with nothing expected", m_axis_data);
                end else begin
                    chk("beat_data", m_axis_data, exp_q[0].data);
                    chk("beat_last", m_axis_last, exp_q[0].last);
                    if (m_axis_ready) begin
                        exp_intr = exp_q[0].last;
                        void'(exp_q.pop_front());
                        hs_count++;
                        if (pp_first < 0) pp_first = cyc;
                        pp_last = cyc;
                    end
                end
            end else begin
                chk("last_when_idle", m_axis_last, 1'b0);
            end
            prev_stall = m_axis_valid && !m_axis_ready;
        end
    end

    task automatic drive_row(input int r);
        for (int c = 0; c < 8; c++) input_data[c] = blk[r*8 + c];
        input_valid = 1'b1;
    endtask

    // Raster order equals row order, so a row's beats join the tail in column order.
    task automatic accept_row(input int r);
        for (int c = 0; c < 8; c++)
            exp_q.push_back('{data: AXIS_W'(blk[r*8 + c]), last: (r == 7 && c == 7)});
    endtask

    task automatic send_block(input int first_row, input int gap_max);
        int guard;
        for (int r = first_row; r < 8; r++) begin
            if (gap_max > 0) begin
                input_valid = 1'b0;
                repeat ($urandom_range(0, gap_max)) @(posedge i_clk);
                #1;
            end
            drive_row(r);
            guard = 0;
            forever begin
                @(negedge i_clk);
                if (input_ready) begin
                    accept_row(r);
                    @(posedge i_clk);
                    #1;
                    break;
                end
                @(posedge i_clk);
                #1;
                guard++;
                if (guard > 500) begin
                    timeout_fail("row_accept");
                    break;
                end
            end
        end
        input_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int guard = 0;
        while ((exp_q.size() != 0 || m_axis_valid) && guard < 3000) begin
            @(posedge i_clk);
            #1;
            guard++;
        end
        if (guard >= 3000) timeout_fail(name);
        repeat (2) @(posedge i_clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_input_ready"}, input_ready, 1'b1);
        chk({tag, "_valid"}, m_axis_valid, 1'b0);
        chk({tag, "_last"}, m_axis_last, 1'b0);
        chk({tag, "_data"}, m_axis_data, '0);
        chk({tag, "_intr"}, o_intr, 1'b0);
    endtask

    task automatic random_block();
        for (int i = 0; i < 64; i++) blk[i] = PIX_W'($urandom);
    endtask

    initial begin
        int base;
        int guard;
        for (int c = 0; c < 8; c++) input_data[c] = '0;
        repeat (3) @(posedge i_clk);
        #1;
        check_idle_outputs("reset");
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;

        // Single block with pixel value = index.
        for (int i = 0; i < 64; i++) blk[i] = PIX_W'(i);
        base = intr_count;
        send_block(0, 0);
        wait_drain("drain_ramp");
        chk("intr_pulses_ramp", intr_count - base, 1);

        // Width rule: upper stream bits read zero.
        for (int i = 0; i < 64; i++) blk[i] = 24'hABCDEF;
        send_block(0, 2);
        wait_drain("drain_width");

        // Backpressure with random data and random row gaps.
        bp_mode = 1'b1;
        for (int b = 0; b < 2; b++) begin
            random_block();
            send_block(0, 3);
        end
        wait_drain("drain_bp");

`ifndef SER_PINGPONG_EN
        // Junk rows held during drain must be ignored.
        random_block();
        send_block(0, 0);
        for (int c = 0; c < 8; c++) input_data[c] = '1;
        input_valid = 1'b1;
        guard = 0;
        forever begin
            @(negedge i_clk);
            if (input_ready) break;
            guard++;
            if (guard > 2000) begin
                timeout_fail("ready_return");
                break;
            end
        end
        random_block();
        drive_row(0);
        accept_row(0);
        @(posedge i_clk);
        #1;
        send_block(1, 0);
        wait_drain("drain_junk");
`endif
        bp_mode = 1'b0;

        // Reset in the middle of a drain.
        random_block();
        base = hs_count;
        send_block(0, 0);
        guard = 0;
        while (hs_count - base < 21 && guard < 500) begin
            @(posedge i_clk);
            #1;
            guard++;
        end
        if (guard >= 500) timeout_fail("beat20");
        i_rst = 1'b0;
        #1;
        check_idle_outputs("midreset");
        exp_q.delete();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        random_block();
        send_block(0, 1);
        wait_drain("drain_after_reset");

`ifdef SER_PINGPONG_EN
        // Three back-to-back blocks must stream without gap cycles.
        base = intr_count;
        pp_first = -1;
        for (int b = 0; b < 3; b++) begin
            random_block();
            send_block(0, 0);
        end
        wait_drain("drain_pingpong");
        chk("pp_span", 64'(pp_last - pp_first), 64'd191);
        chk("pp_intr_pulses", intr_count - base, 3);
`endif

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
